// File: rtl/cpu_ctrl_fsm.sv
// Sequencing controller for the simple RISC CPU: fetch/decode/execute FSM driving every
// datapath and memory strobe. Outputs are registered from the next state so they track state_q exactly.
module cpu_ctrl_fsm #(
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic [2:0] nsel,
  output logic [1:0] vsel,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       bsel,
  output logic       write,
  output logic       loadpc,
  output logic       resetpc,
  output logic       loadir,
  output logic       loadaddr,
  output logic       msel,
  output logic       mwrite,
  output logic       halted
);

  typedef enum logic [4:0] {
    S_RST,
    S_IF1,
    S_IF2,
    S_UPC,
    S_DEC,
    S_WIMM,
    S_GETA,
    S_GETB,
    S_SHA,
    S_EXALU,
    S_EXCMP,
    S_WRC,
    S_ADDR,
    S_LDADR,
    S_MRD,
    S_WRM,
    S_GETBD,
    S_STC,
    S_MWR,
    S_HALT
  } state_t;

  typedef struct packed {
    logic [2:0] nsel;
    logic [1:0] vsel;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic       write;
    logic       loadpc;
    logic       resetpc;
    logic       loadir;
    logic       loadaddr;
    logic       msel;
    logic       mwrite;
    logic       halted;
  } ctrl_t;

  localparam logic [2:0] NSEL_RN = 3'b001;
  localparam logic [2:0] NSEL_RD = 3'b010;
  localparam logic [2:0] NSEL_RM = 3'b100;

  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_IMM8  = 2'b10;
  localparam logic [1:0] VSEL_MDATA = 2'b11;

  localparam logic [2:0] OPC_LDR  = 3'b011;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [1:0] OP_CMP   = 2'b01;

  state_t state_q, state_d;
  ctrl_t  ctrl_q;

  // Strobe pattern for each state; anything not set stays 0.
  function automatic ctrl_t ctrlFor(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_RST: begin
        c.loadpc  = 1'b1;
        c.resetpc = 1'b1;
      end
      S_IF1: c.msel = 1'b0;
      S_IF2: begin
        c.msel   = 1'b0;
        c.loadir = 1'b1;
      end
      S_UPC: c.loadpc = 1'b1;
      S_WIMM: begin
        c.nsel  = NSEL_RN;
        c.vsel  = VSEL_IMM8;
        c.write = 1'b1;
      end
      S_GETA: begin
        c.nsel  = NSEL_RN;
        c.loada = 1'b1;
      end
      S_GETB: begin
        c.nsel  = NSEL_RM;
        c.loadb = 1'b1;
      end
      S_SHA: begin
        c.asel  = 1'b1;
        c.loadc = 1'b1;
      end
      S_EXALU: c.loadc = 1'b1;
      S_EXCMP: c.loads = 1'b1;
      S_WRC: begin
        c.nsel  = NSEL_RD;
        c.vsel  = VSEL_C;
        c.write = 1'b1;
      end
      S_ADDR: begin
        c.bsel  = 1'b1;
        c.loadc = 1'b1;
      end
      S_LDADR: c.loadaddr = 1'b1;
      S_MRD: c.msel = 1'b1;
      S_WRM: begin
        c.msel  = 1'b1;
        c.nsel  = NSEL_RD;
        c.vsel  = VSEL_MDATA;
        c.write = 1'b1;
      end
      S_GETBD: begin
        c.nsel  = NSEL_RD;
        c.loadb = 1'b1;
      end
      S_STC: begin
        c.asel  = 1'b1;
        c.loadc = 1'b1;
      end
      S_MWR: begin
        c.msel   = 1'b1;
        c.mwrite = 1'b1;
      end
      S_HALT: c.halted = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  // The compare step is split into its own state so the loads/loadc choice stays a pure state decode.
  always_comb begin
    state_d = S_RST;
    case (state_q)
      S_RST:  state_d = S_IF1;
      S_IF1:  state_d = S_IF2;
      S_IF2:  state_d = S_UPC;
      S_UPC:  state_d = S_DEC;
      S_DEC: begin
        casez ({opcode, op})
          5'b110_10: state_d = S_WIMM;
          5'b110_00: state_d = S_GETB;
          5'b101_??: state_d = S_GETA;
          5'b011_00: state_d = S_GETA;
          5'b100_00: state_d = S_GETA;
          5'b111_??: state_d = S_HALT;
          default:   state_d = HALT_ON_ILLEGAL ? S_HALT : S_IF1;
        endcase
      end
      S_WIMM: state_d = S_IF1;
      S_GETA: state_d = (opcode == OPC_ALU) ? S_GETB : S_ADDR;
      S_GETB: begin
        if (opcode == OPC_MOV)
          state_d = S_SHA;
        else if (op == OP_CMP)
          state_d = S_EXCMP;
        else
          state_d = S_EXALU;
      end
      S_SHA:   state_d = S_WRC;
      S_EXALU: state_d = S_WRC;
      S_EXCMP: state_d = S_IF1;
      S_WRC:   state_d = S_IF1;
      S_ADDR:  state_d = S_LDADR;
      S_LDADR: state_d = (opcode == OPC_LDR) ? S_MRD : S_GETBD;
      S_MRD:   state_d = S_WRM;
      S_WRM:   state_d = S_IF1;
      S_GETBD: state_d = S_STC;
      S_STC:   state_d = S_MWR;
      S_MWR:   state_d = S_IF1;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RST;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_RST;
      ctrl_q  <= ctrlFor(S_RST);
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrlFor(state_d);
    end
  end

  assign nsel     = ctrl_q.nsel;
  assign vsel     = ctrl_q.vsel;
  assign loada    = ctrl_q.loada;
  assign loadb    = ctrl_q.loadb;
  assign loadc    = ctrl_q.loadc;
  assign loads    = ctrl_q.loads;
  assign asel     = ctrl_q.asel;
  assign bsel     = ctrl_q.bsel;
  assign write    = ctrl_q.write;
  assign loadpc   = ctrl_q.loadpc;
  assign resetpc  = ctrl_q.resetpc;
  assign loadir   = ctrl_q.loadir;
  assign loadaddr = ctrl_q.loadaddr;
  assign msel     = ctrl_q.msel;
  assign mwrite   = ctrl_q.mwrite;
  assign halted   = ctrl_q.halted;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed bench for cpu_ctrl_fsm: walks each instruction class cycle by cycle and checks the full
// strobe vector. A second instance with HALT_ON_ILLEGAL=0 covers the illegal-opcode-as-NOP case.
module tb_cpu_ctrl_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] opcode;
  logic [1:0] op;

  logic [2:0] nsel, nNsel;
  logic [1:0] vsel, nVsel;
  logic loada, loadb, loadc, loads, asel, bsel, write, loadpc, resetpc;
  logic loadir, loadaddr, msel, mwrite, halted;
  logic nLoada, nLoadb, nLoadc, nLoads, nAsel, nBsel, nWrite, nLoadpc, nResetpc;
  logic nLoadir, nLoadaddr, nMsel, nMwrite, nHalted;

  logic [18:0] obsMain, obsNop;
  logic [18:0] seqBuf [10];

  int checks   = 0;
  int failures = 0;

  // Vector layout: {nsel[2:0], vsel[1:0], loada, loadb, loadc, loads, asel, bsel, write,
  //                 loadpc, resetpc, loadir, loadaddr, msel, mwrite, halted}
  localparam logic [18:0] E_IDLE  = 19'h00000;
  localparam logic [18:0] E_RST   = 19'h00060;
  localparam logic [18:0] E_IF2   = 19'h00010;
  localparam logic [18:0] E_UPC   = 19'h00040;
  localparam logic [18:0] E_WIMM  = 19'h18080;
  localparam logic [18:0] E_GETA  = 19'h12000;
  localparam logic [18:0] E_GETB  = 19'h41000;
  localparam logic [18:0] E_SHA   = 19'h00A00;
  localparam logic [18:0] E_EXE   = 19'h00800;
  localparam logic [18:0] E_CMP   = 19'h00400;
  localparam logic [18:0] E_WRC   = 19'h20080;
  localparam logic [18:0] E_ADDR  = 19'h00900;
  localparam logic [18:0] E_LDADR = 19'h00008;
  localparam logic [18:0] E_MRD   = 19'h00004;
  localparam logic [18:0] E_WRM   = 19'h2C084;
  localparam logic [18:0] E_GETBD = 19'h21000;
  localparam logic [18:0] E_STC   = 19'h00A00;
  localparam logic [18:0] E_MWR   = 19'h00006;
  localparam logic [18:0] E_HALT  = 19'h00001;

  cpu_ctrl_fsm dut (
    .clk(clk), .reset(reset), .opcode(opcode), .op(op),
    .nsel(nsel), .vsel(vsel), .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .bsel(bsel), .write(write), .loadpc(loadpc), .resetpc(resetpc),
    .loadir(loadir), .loadaddr(loadaddr), .msel(msel), .mwrite(mwrite), .halted(halted)
  );

  cpu_ctrl_fsm #(.HALT_ON_ILLEGAL(1'b0)) dutNop (
    .clk(clk), .reset(reset), .opcode(opcode), .op(op),
    .nsel(nNsel), .vsel(nVsel), .loada(nLoada), .loadb(nLoadb), .loadc(nLoadc), .loads(nLoads),
    .asel(nAsel), .bsel(nBsel), .write(nWrite), .loadpc(nLoadpc), .resetpc(nResetpc),
    .loadir(nLoadir), .loadaddr(nLoadaddr), .msel(nMsel), .mwrite(nMwrite), .halted(nHalted)
  );

  assign obsMain = {nsel, vsel, loada, loadb, loadc, loads, asel, bsel, write,
                    loadpc, resetpc, loadir, loadaddr, msel, mwrite, halted};
  assign obsNop  = {nNsel, nVsel, nLoada, nLoadb, nLoadc, nLoads, nAsel, nBsel, nWrite,
                    nLoadpc, nResetpc, nLoadir, nLoadaddr, nMsel, nMwrite, nHalted};

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [18:0] observed, input logic [18:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%05h expected=%05h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] opc, input logic [1:0] o);
    opcode = opc;
    op     = o;
  endtask

  task automatic stepCheck(input string tag, input logic [18:0] expected);
    @(posedge clk);
    #1;
    checkOutput(tag, obsMain, expected);
  endtask

  task automatic runInstr(input string name, input logic [2:0] opc, input logic [1:0] o,
                          input int n, input logic [18:0] seq [10]);
    applyStimulus(opc, o);
    for (int i = 0; i < n; i++)
      stepCheck($sformatf("%s_c%0d", name, i + 1), seq[i]);
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(3'b000, 2'b00);
    #2 reset = 1'b0;
    #1;
    checkOutput("reset_async", obsMain, E_RST);
    checkOutput("reset_async_nop", obsNop, E_RST);
    stepCheck("reset_hold1", E_RST);
    stepCheck("reset_hold2", E_RST);
    @(negedge clk) reset = 1'b1;

    seqBuf = '{E_IDLE, E_IF2, E_UPC, E_IDLE, E_WIMM, E_IDLE, E_IDLE, E_IDLE, E_IDLE, E_IDLE};
    runInstr("movi", 3'b110, 2'b10, 5, seqBuf);

    seqBuf = '{E_IDLE, E_IF2, E_UPC, E_IDLE, E_GETA, E_GETB, E_EXE, E_WRC, E_IDLE, E_IDLE};
    runInstr("add", 3'b101, 2'b00, 8, seqBuf);

    seqBuf = '{E_IDLE, E_IF2, E_UPC, E_IDLE, E_GETA, E_GETB, E_CMP, E_IDLE, E_IDLE, E_IDLE};
    runInstr("cmp", 3'b101, 2'b01, 7, seqBuf);

    seqBuf = '{E_IDLE, E_IF2, E_UPC, E_IDLE, E_GETA, E_ADDR, E_LDADR, E_MRD, E_WRM, E_IDLE};
    runInstr("ldr", 3'b011, 2'b00, 9, seqBuf);

    seqBuf = '{E_IDLE, E_IF2, E_UPC, E_IDLE, E_GETA, E_ADDR, E_LDADR, E_GETBD, E_STC, E_MWR};
    runInstr("str", 3'b100, 2'b00, 10, seqBuf);

    seqBuf = '{E_IDLE, E_IF2, E_UPC, E_IDLE, E_GETB, E_SHA, E_WRC, E_IDLE, E_IDLE, E_IDLE};
    runInstr("mov", 3'b110, 2'b00, 7, seqBuf);

    // Abort a store while in STC: the memory write must never happen.
    seqBuf = '{E_IDLE, E_IF2, E_UPC, E_IDLE, E_GETA, E_ADDR, E_LDADR, E_GETBD, E_STC, E_IDLE};
    runInstr("str_abort", 3'b100, 2'b00, 9, seqBuf);
    #1 reset = 1'b0;
    #1;
    checkOutput("abort_async_rst", obsMain, E_RST);
    stepCheck("abort_hold_rst", E_RST);
    @(negedge clk) reset = 1'b1;
    seqBuf = '{E_IDLE, E_IF2, E_UPC, E_IDLE, E_WIMM, E_IDLE, E_IDLE, E_IDLE, E_IDLE, E_IDLE};
    runInstr("resume_movi", 3'b110, 2'b10, 5, seqBuf);

    // Illegal opcode 000: halts the default instance, falls through to fetch on the NOP instance.
    applyStimulus(3'b000, 2'b00);
    seqBuf = '{E_IDLE, E_IF2, E_UPC, E_IDLE, E_IDLE, E_IDLE, E_IDLE, E_IDLE, E_IDLE, E_IDLE};
    for (int i = 0; i < 4; i++) begin
      stepCheck($sformatf("ill_c%0d", i + 1), seqBuf[i]);
      checkOutput($sformatf("ill_nop_c%0d", i + 1), obsNop, seqBuf[i]);
    end
    stepCheck("ill_c5_halt", E_HALT);
    checkOutput("ill_nop_c5_if1", obsNop, E_IDLE);
    stepCheck("ill_c6_halt", E_HALT);
    checkOutput("ill_nop_c6_if2", obsNop, E_IF2);

    #1 reset = 1'b0;
    #1;
    checkOutput("halt_exit_rst", obsMain, E_RST);
    @(negedge clk) reset = 1'b1;

    seqBuf = '{E_IDLE, E_IF2, E_UPC, E_IDLE, E_HALT, E_IDLE, E_IDLE, E_IDLE, E_IDLE, E_IDLE};
    runInstr("halt", 3'b111, 2'b00, 5, seqBuf);
    applyStimulus(3'b110, 2'b10);
    for (int i = 0; i < 20; i++)
      stepCheck($sformatf("halt_stay%0d", i + 1), E_HALT);
    checkOutput("halt_nop_inst", obsNop, E_HALT);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
